// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP word,
// PC increment and word-alignment helper.
package if_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_DRAIN
   } if_state_e;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] PC_INC = 32'd4;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register with next-PC select: redirect > advance > hold.
// Ports: clk, rst (async active-low), redirect/redirect_pc, advance -> pc.
module if_pc_gen
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= align_pc(redirect_pc);
      end else if (advance) begin
         pc <= pc + PC_INC;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: imem request FSM, stall buffer, IF/ID outputs.
// Ports: clk, rst (async active-low), stall, redirect, redirect_pc,
//   imem_req/imem_addr/imem_ack/imem_rdata, IF_PC, IF_inst, IF_valid.
// Macro IF_PERF_CNT_EN adds fetch_cnt and stall_cnt outputs.
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_inst,
   output logic        IF_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   if_state_e   state;
   if_state_e   nxt;
   logic [31:0] pc;
   logic [31:0] buffer;
   logic [31:0] drain_addr;
   logic        advance;

   assign advance = IF_valid && !stall;

   if_pc_gen #(
      .RESET_PC(RESET_PC)
   ) u_pc_gen (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .advance    (advance),
      .pc         (pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: nxt = S_REQ;
         S_REQ: begin
            if (redirect) begin
               nxt = imem_ack ? S_REQ : S_DRAIN;
            end else if (imem_ack && stall) begin
               nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect || !stall) begin
               nxt = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imem_ack) begin
               nxt = S_REQ;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state == S_REQ) || (state == S_DRAIN);
      // A draining request must keep its original address even
      // though pc already points at the redirect target.
      imem_addr = (state == S_DRAIN) ? drain_addr : pc;
      IF_valid  = !redirect &&
                  (((state == S_REQ) && imem_ack) ||
                   (state == S_HOLD));
      IF_PC     = pc;
      IF_inst   = NOP;
      if (IF_valid) begin
         IF_inst = (state == S_HOLD) ? buffer : imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buffer     <= NOP;
         drain_addr <= RESET_PC;
      end else begin
         if ((state == S_REQ) && imem_ack && stall && !redirect) begin
            buffer <= imem_rdata;
         end
         if ((state == S_REQ) && redirect && !imem_ack) begin
            drain_addr <= pc;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (advance) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if ((state != S_IDLE) && (!IF_valid || stall)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: abstract fetch model plus
// hand-computed directed expectations.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ack_want;

   logic        imem_req,  imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic        imem_ack,  imem_ack2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic [31:0] IF_PC,   IF_PC2;
   logic [31:0] IF_inst, IF_inst2;
   logic        IF_valid, IF_valid2;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_ack    = ack_want & imem_req;
   assign imem_rdata  = mem(imem_addr);
   assign imem_ack2   = ack_want & imem_req2;
   assign imem_rdata2 = mem(imem_addr2);

   if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .IF_PC(IF_PC), .IF_inst(IF_inst),
      .IF_valid(IF_valid)
`ifdef IF_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req2),
      .imem_addr(imem_addr2), .imem_ack(imem_ack2),
      .imem_rdata(imem_rdata2), .IF_PC(IF_PC2), .IF_inst(IF_inst2),
      .IF_valid(IF_valid2)
`ifdef IF_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Behavioural model: tracks program counter, whether a word is
   // being held for a stalled consumer, and whether an abandoned
   // request is still outstanding in memory.
   logic        m_started, m_held, m_drain;
   logic [31:0] m_pc, m_hword, m_daddr;
   int unsigned m_fetch, m_stall;

   always @(negedge clk) begin
      logic        e_req, e_valid, ackd;
      logic [31:0] e_addr, e_inst;
      if (!rst) begin
         chk("rst_req", {31'd0, imem_req}, 32'd0);
         chk("rst_valid", {31'd0, IF_valid}, 32'd0);
         chk("rst_inst", IF_inst, 32'd0);
         chk("rst_pc", IF_PC, 32'd0);
`ifdef IF_PERF_CNT_EN
         chk("rst_fcnt", fetch_cnt, 32'd0);
         chk("rst_scnt", stall_cnt, 32'd0);
`endif
         m_started = 0; m_held = 0; m_drain = 0;
         m_pc = 0; m_hword = 0; m_daddr = 0;
         m_fetch = 0; m_stall = 0;
      end else begin
         e_req = 0; e_addr = m_pc; e_valid = 0; e_inst = 0;
         if (!m_started) begin
            e_req = 0;
         end else if (m_held) begin
            e_valid = !redirect;
            e_inst  = m_hword;
         end else if (m_drain) begin
            e_req  = 1;
            e_addr = m_daddr;
         end else begin
            e_req   = 1;
            e_valid = ack_want && !redirect;
            e_inst  = mem(m_pc);
         end
         if (!e_valid) e_inst = 0;
         ackd = ack_want && e_req;

         chk("m_req", {31'd0, imem_req}, {31'd0, e_req});
         if (e_req) chk("m_addr", imem_addr, e_addr);
         chk("m_valid", {31'd0, IF_valid}, {31'd0, e_valid});
         chk("m_inst", IF_inst, e_inst);
         chk("m_pc", IF_PC, m_pc);
`ifdef IF_PERF_CNT_EN
         chk("m_fcnt", fetch_cnt, m_fetch);
         chk("m_scnt", stall_cnt, m_stall);
`endif
         if (m_started) begin
            if (e_valid && !stall) m_fetch++;
            if (!e_valid || stall) m_stall++;
         end

         if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (redirect) begin
            if (e_req && !ackd) begin
               if (!m_drain) m_daddr = m_pc;
               m_drain = 1;
            end else begin
               m_drain = 0;
            end
            m_held = 0;
            m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else if (m_drain) begin
            if (ackd) m_drain = 0;
         end else if (e_valid) begin
            if (!stall) begin
               m_pc = m_pc + 4;
               m_held = 0;
            end else if (!m_held) begin
               m_held = 1;
               m_hword = e_inst;
            end
         end
      end
   end

   task automatic cyc(input logic a, input logic s, input logic r,
                      input logic [31:0] t);
      @(posedge clk);
      #1;
      ack_want = a; stall = s; redirect = r; redirect_pc = t;
      @(negedge clk);
      #1;
   endtask

   task automatic release_rst();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1; ack_want = 1; stall = 0; redirect = 0;
      @(negedge clk);
      #1;
      chk("idle_valid", {31'd0, IF_valid}, 32'd0);
      chk("idle_req", {31'd0, imem_req}, 32'd0);
   endtask

   initial begin
      rst = 0; ack_want = 0; stall = 0; redirect = 0; redirect_pc = 0;

      // Streaming after reset, plus wrap on the second instance
      release_rst();
      chk("w_idle_pc", IF_PC2, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 0);
      chk("s_pc0", IF_PC, 32'h0);
      chk("s_v0", {31'd0, IF_valid}, 32'd1);
      chk("s_i0", IF_inst, 32'h1357_6420);
      chk("w_pc0", IF_PC2, 32'hFFFF_FFFC);
      chk("w_addr0", imem_addr2, 32'hFFFF_FFFC);
      chk("w_v0", {31'd0, IF_valid2}, 32'd1);
      cyc(1, 0, 0, 0);
      chk("s_pc4", IF_PC, 32'h4);
      chk("w_pc1", IF_PC2, 32'h0);
      chk("w_v1", {31'd0, IF_valid2}, 32'd1);
      cyc(1, 0, 0, 0);
      chk("s_pc8", IF_PC, 32'h8);
      cyc(1, 0, 0, 0);
      chk("s_pc12", IF_PC, 32'hC);
      chk("s_v12", {31'd0, IF_valid}, 32'd1);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
      // Asynchronous reset in the middle of an unacked request
      rst = 0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_valid", {31'd0, IF_valid}, 32'd0);
      chk("arst_inst", IF_inst, 32'd0);
      chk("arst_pc", IF_PC, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("arst_fcnt", fetch_cnt, 32'd0);
      chk("arst_scnt", stall_cnt, 32'd0);
`endif

      // Stall with a word held at pc=8
      release_rst();
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("h_pc_a", IF_PC, 32'h8);
      chk("h_i_a", IF_inst, 32'h135F_6428);
      cyc(1, 1, 0, 0);
      chk("h_req1", {31'd0, imem_req}, 32'd0);
      chk("h_i1", IF_inst, 32'h135F_6428);
      cyc(1, 1, 0, 0);
      chk("h_pc2", IF_PC, 32'h8);
      cyc(1, 0, 0, 0);
      chk("h_pc3", IF_PC, 32'h8);
      chk("h_v3", {31'd0, IF_valid}, 32'd1);
      chk("h_req3", {31'd0, imem_req}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("h_pc12", IF_PC, 32'hC);
      chk("h_req12", {31'd0, imem_req}, 32'd1);

      // Redirect while the pc=4 request is still outstanding
      rst = 0;
      release_rst();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 32'h0000_0103);
      chk("r_v0", {31'd0, IF_valid}, 32'd0);
      cyc(0, 0, 0, 0);
      chk("r_daddr", imem_addr, 32'h4);
      chk("r_dreq", {31'd0, imem_req}, 32'd1);
      cyc(1, 0, 0, 0);
      chk("r_drop", {31'd0, IF_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("r_pc", IF_PC, 32'h100);
      chk("r_inst", IF_inst, 32'h1257_6520);
      // Redirect and stall together with ack
      cyc(1, 1, 1, 32'h0000_0200);
      chk("rs_v", {31'd0, IF_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("rs_pc", IF_PC, 32'h200);
      chk("rs_valid", {31'd0, IF_valid}, 32'd1);
      // Redirect during drain
      cyc(0, 0, 1, 32'h0000_0300);
      cyc(0, 0, 1, 32'h0000_0401);
      cyc(1, 0, 0, 0);
      chk("rd_addr", imem_addr, 32'h204);
      chk("rd_v", {31'd0, IF_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("rd_pc", IF_PC, 32'h400);
      // Redirect while holding
      cyc(1, 1, 0, 0);
      cyc(0, 1, 1, 32'h0000_0500);
      chk("rh_v", {31'd0, IF_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("rh_pc", IF_PC, 32'h500);

      // Mixed traffic checked by the model only
      repeat (300) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 stall  in  1  SHALL mean the IF/ID register is not loading this cycle (hazard unit hold).
REQ-005 redirect  in  1  SHALL mean a taken branch or jump is requesting a new fetch address.
REQ-006 redirect_pc  in  32  SHALL be the redirect target; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  out  1  SHALL be the instruction-memory request.
REQ-008 imem_addr  out  32  SHALL be the word-aligned fetch address.
REQ-009 imem_ack  in  1  SHALL mean imem_rdata is valid this cycle for the held request.
REQ-010 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-011 IF_PC  out  32  SHALL be the address of the instruction presented on IF_inst.
REQ-012 IF_inst  out  32  SHALL be the instruction for the IF/ID register, 32'h0000_0000 (NOP) when IF_valid=0.
REQ-013 IF_valid  out  1  SHALL mean IF_inst/IF_PC hold a real instruction this cycle.

Function
REQ-014 States SHALL be IDLE, REQ, HOLD, DRAIN; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-015 In REQ, imem_req=1 and imem_addr=pc; addr SHALL stay stable until the cycle imem_ack=1.
REQ-016 REQ with ack, no redirect: IF_inst=imem_rdata, IF_PC=pc, IF_valid=1 combinationally in that same cycle.
REQ-017 Delivery SHALL be consumed when IF_valid=1 and stall=0; on consume pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), stay/enter REQ.
REQ-018 REQ with ack and stall=1: capture word into buffer, go HOLD, pc unchanged.
REQ-019 HOLD: imem_req=0, IF_inst=buffer, IF_PC=pc, IF_valid=1; on stall=0 pc <= pc+4, go REQ.
REQ-020 redirect SHALL have priority over stall and delivery: IF_valid=0 that cycle, pc <= {redirect_pc[31:2],2'b00}.
REQ-021 redirect in REQ without ack: SHALL go DRAIN, keeping imem_req=1 with old addr until ack; the acked word is discarded (IF_valid=0), then REQ at new pc.
REQ-022 redirect in HOLD, or in REQ together with ack: buffer/word discarded, go REQ at new pc next cycle.
REQ-023 redirect in DRAIN SHALL update the target pc only; the draining request is still discarded.
REQ-024 Steady-state throughput SHALL be one instruction per cycle when imem_ack=1 every cycle and stall=0.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, buffer=0, imem_req=0, IF_valid=0, IF_inst=0, IF_PC=RESET_PC.
REQ-026 Reset asserted mid-request SHALL abandon the request; no acked data is delivered after reset release until a new REQ.

Configuration
REQ-027 Macro IF_PERF_CNT_EN defined: SHALL add outputs fetch_cnt[31:0] (consumed instructions) and stall_cnt[31:0] (cycles with IF_valid=0 or stall=1 outside IDLE), both reset to 0 and wrapping.
REQ-028 Macro undefined: SHALL omit those ports and counters; all other behaviour identical.

Structure
REQ-029 Shared package if_pkg SHALL hold the state enumeration, NOP constant 32'h0000_0000 and PC increment constant 4.
REQ-030 One sub-module if_pc_gen SHALL hold the pc register and next-pc selection (redirect, +4, hold); the FSM and buffer stay in if_stage.

Verification
REQ-031 Reset release, ack every cycle, stall=0 -> IF_PC 0,4,8,12 on consecutive cycles after one IDLE cycle, IF_valid=1 each.
REQ-032 Ack with stall=1 for 3 cycles at pc=8 -> IF_PC=8 and IF_inst constant for 4 cycles, imem_req=0 during HOLD, then fetch of 12.
REQ-033 redirect to 32'h0000_0103 while pc=4 request unacked, ack 2 cycles later -> acked word dropped, next IF_PC=32'h0000_0100.
REQ-034 redirect and stall in the same cycle as ack -> IF_valid=0, next fetch at redirect target.
REQ-035 RESET_PC=32'hFFFF_FFFC, two acks -> IF_PC FFFF_FFFC then 0000_0000.
REQ-036 rst=0 during REQ with imem_ack=0 -> all outputs at reset values immediately; with IF_PERF_CNT_EN, counters read 0.
